// File: rtl/io_port_controller_if.sv
// io_port_controller_if: cpu port, tx device and rx device signals of io_port_controller.
interface io_port_controller_if;
    logic [7:0] cpu_data_in;
    logic       cpu_write;
    logic [7:0] cpu_data_out;
    logic       rx_irq;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       tx_full;
    logic       tx_overflow;

    modport slave (
        input  cpu_data_in, cpu_write, tx_ready, rx_data, rx_valid,
        output cpu_data_out, rx_irq, tx_data, tx_valid, rx_ready, tx_full, tx_overflow
    );

    modport master (
        output cpu_data_in, cpu_write, tx_ready, rx_data, rx_valid,
        input  cpu_data_out, rx_irq, tx_data, tx_valid, rx_ready, tx_full, tx_overflow
    );
endinterface

// File: rtl/io_port_controller.sv
// io_port_controller: buffered cpu OUT -> device tx FIFO and throttled device -> cpu IN capture with irq.
module io_port_controller #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 8
) (
    input logic                 clk,
    input logic                 async_nreset,
    io_port_controller_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {IDLE, HOLD} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q;
    logic          push, pop;
    logic [7:0]    dout_q;
    logic          irq_q, rdy_q;
    state_e        state_q;
    logic [HW-1:0] hold_q;

    // a pop frees a slot in the same cycle, so a full FIFO still accepts a write then
    always_comb begin
        pop   = (cnt_q != '0) && bus.tx_ready;
        push  = bus.cpu_write && ((cnt_q != (AW+1)'(DEPTH)) || pop);
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= bus.cpu_data_in;
            wr_q  <= wr_q + AW'(push);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_d;
            ovf_q <= ovf_q | (bus.cpu_write & ~push);
        end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q <= IDLE;
            dout_q  <= '0;
            irq_q   <= 1'b0;
            rdy_q   <= 1'b1;
            hold_q  <= '0;
        end else if (state_q == IDLE) begin
            irq_q <= bus.rx_valid;
            if (bus.rx_valid) begin
                dout_q  <= bus.rx_data;
                hold_q  <= HW'(HOLD_CYCLES);
                rdy_q   <= 1'b0;
                state_q <= HOLD;
            end
        end else begin
            irq_q  <= 1'b0;
            hold_q <= hold_q - HW'(1);
            if (hold_q == HW'(1)) begin
                rdy_q   <= 1'b1;
                state_q <= IDLE;
            end
        end
    end

    assign bus.tx_valid     = (cnt_q != '0);
    assign bus.tx_data      = mem_q[rd_q];
    assign bus.tx_full      = (cnt_q == (AW+1)'(DEPTH));
    assign bus.tx_overflow  = ovf_q;
    assign bus.cpu_data_out = dout_q;
    assign bus.rx_irq       = irq_q;
    assign bus.rx_ready     = rdy_q;
endmodule

// File: tb/tb_io_port_controller.sv
// tb_io_port_controller: random and directed stimulus checked every cycle against a queue/countdown model.
module tb_io_port_controller;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    io_port_controller_if bus();

    io_port_controller #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk),
        .async_nreset(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mq[$];
    bit         m_ovf  = 1'b0;
    logic [7:0] m_dout = 8'h00;
    bit         m_irq  = 1'b0;
    int         m_left = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: FIFO as a queue, rx throttle as a count of remaining busy cycles
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_ovf  = 1'b0;
                m_dout = 8'h00;
                m_irq  = 1'b0;
                m_left = 0;
            end else begin
                bit pop, push;
                pop  = (mq.size() != 0) && bus.tx_ready;
                push = bus.cpu_write && ((mq.size() < DEPTH) || pop);
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(bus.cpu_data_in);
                else if (bus.cpu_write) m_ovf = 1'b1;
                m_irq = 1'b0;
                if (m_left > 0) m_left--;
                else if (bus.rx_valid) begin
                    m_dout = bus.rx_data;
                    m_irq  = 1'b1;
                    m_left = HOLD;
                end
            end
        end
    end

    initial begin
        @(negedge rst_n);
        forever begin
            @(negedge clk);
            check("tx_valid", bus.tx_valid, mq.size() != 0);
            if (mq.size() != 0) check("tx_data", bus.tx_data, mq[0]);
            check("tx_full", bus.tx_full, mq.size() == DEPTH);
            check("tx_overflow", bus.tx_overflow, m_ovf);
            check("cpu_data_out", bus.cpu_data_out, m_dout);
            check("rx_irq", bus.rx_irq, m_irq);
            check("rx_ready", bus.rx_ready, m_left == 0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.cpu_write   = 1'b0;
        bus.cpu_data_in = 8'h00;
        bus.tx_ready    = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
    endtask

    task automatic do_reset;
        idle_inputs();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_tx_full", bus.tx_full, 0);
        check("rst_tx_overflow", bus.tx_overflow, 0);
        check("rst_cpu_data_out", bus.cpu_data_out, 0);
        check("rst_rx_irq", bus.rx_irq, 0);
        check("rst_rx_ready", bus.rx_ready, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic write(input logic [7:0] d);
        bus.cpu_data_in = d;
        bus.cpu_write   = 1'b1;
        tick();
        bus.cpu_write   = 1'b0;
    endtask

    initial begin
        logic [7:0] exp4[4];
        idle_inputs();
        #1 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        do_reset();

        // single byte, held under back-pressure
        write(8'h5A);
        check("t1_valid", bus.tx_valid, 1);
        check("t1_data", bus.tx_data, 8'h5A);
        repeat (10) begin
            tick();
            check("t1_hold", bus.tx_data, 8'h5A);
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check("t1_done", bus.tx_valid, 0);

        // fill, overflow, drain
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            write(8'(i));
            if (i == 4) check("t2_full", bus.tx_full, 1);
            if (i == 5) check("t2_ovf", bus.tx_overflow, 1);
        end
        bus.tx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("t2_drain", bus.tx_data, 8'(i));
            tick();
        end
        check("t2_empty", bus.tx_valid, 0);

        // write into a full FIFO while it pops
        do_reset();
        for (int i = 0; i < 4; i++) write(8'h10 + 8'(i));
        bus.tx_ready    = 1'b1;
        bus.cpu_data_in = 8'h77;
        bus.cpu_write   = 1'b1;
        tick();
        bus.cpu_write = 1'b0;
        check("t3_full", bus.tx_full, 1);
        check("t3_ovf", bus.tx_overflow, 0);
        exp4 = '{8'h11, 8'h12, 8'h13, 8'h77};
        for (int i = 0; i < 4; i++) begin
            check("t3_drain", bus.tx_data, exp4[i]);
            tick();
        end
        check("t3_empty", bus.tx_valid, 0);

        // rx capture with continuous rx_valid, data change during hold-off ignored
        do_reset();
        bus.rx_data  = 8'hC3;
        bus.rx_valid = 1'b1;
        tick();
        check("t4_dout", bus.cpu_data_out, 8'hC3);
        check("t4_irq", bus.rx_irq, 1);
        check("t4_rdy", bus.rx_ready, 0);
        bus.rx_data = 8'h3C;
        for (int k = 1; k <= HOLD; k++) begin
            tick();
            check("t4_irq_low", bus.rx_irq, 0);
            check("t4_rdy_win", bus.rx_ready, k == HOLD);
            check("t4_dout_hold", bus.cpu_data_out, 8'hC3);
        end
        tick();
        check("t4_irq2", bus.rx_irq, 1);
        check("t4_dout2", bus.cpu_data_out, 8'h3C);
        bus.rx_valid = 1'b0;

        // reset mid hold-off with two bytes pending
        do_reset();
        bus.rx_data     = 8'h99;
        bus.rx_valid    = 1'b1;
        write(8'hAA);
        bus.rx_valid    = 1'b0;
        write(8'hBB);
        tick();
        check("t5_pending", bus.tx_valid, 1);
        check("t5_hold", bus.rx_ready, 0);
        do_reset();
        check("t5_valid", bus.tx_valid, 0);
        check("t5_rdy", bus.rx_ready, 1);
        bus.tx_ready = 1'b1;
        repeat (5) begin
            tick();
            check("t5_no_stale", bus.tx_valid, 0);
        end

        // wrap-around with continuous drain
        do_reset();
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++) write(8'hA0 + 8'(i));
        tick();
        check("t6_ovf", bus.tx_overflow, 0);
        check("t6_empty", bus.tx_valid, 0);

        // random traffic with varying back-pressure
        for (int p = 0; p < 3; p++) begin
            do_reset();
            repeat (1000) begin
                bus.cpu_write   = 1'($urandom_range(0, 1));
                bus.cpu_data_in = 8'($urandom);
                bus.tx_ready    = ($urandom_range(0, 3) < p + 1);
                bus.rx_valid    = 1'($urandom_range(0, 1));
                bus.rx_data     = 8'($urandom);
                tick();
            end
        end

        idle_inputs();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/io_port_controller.md
Name: io_port_controller

Overview:
- Sits between the 8-bit cpu I/O port (OUT strobe/data, IN data, trap_trigger input) and an external byte-wide device.
- Output path: every cpu OUT write is buffered in a FIFO and drained to the device over a valid/ready handshake.
- Input path: device bytes are captured into a holding register that the cpu samples on IN. A capture raises a one-cycle interrupt pulse for the cpu trap_trigger input.
- Reception is throttled by a hold-off counter so the cpu has time to read each byte.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- HOLD_CYCLES, 8, cycles rx_ready stays low after a byte is captured; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- async_nreset  input  1  asynchronous active-low reset.
- cpu_data_in  input  8  cpu OUT data (from cpu io_data_output).
- cpu_write  input  1  cpu OUT strobe (from cpu io_write), one-cycle pulse per OUT.
- cpu_data_out  output  8  byte presented to cpu IN (to cpu io_data_input).
- rx_irq  output  1  one-cycle pulse on byte capture (to cpu trap_trigger).
- tx_data  output  8  byte offered to device.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  device accepts tx_data.
- rx_data  input  8  byte from device.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  controller accepts rx_data.
- tx_full  output  1  FIFO holds DEPTH entries.
- tx_overflow  output  1  sticky: a cpu write was dropped.

Behaviour:
- Reset (asynchronous, immediate): FIFO pointers and count 0, tx_valid 0, tx_data 0, tx_full 0, tx_overflow 0, cpu_data_out 0, rx_irq 0, rx_ready 1, rx FSM in IDLE, hold counter 0.
  - Reset mid-transfer discards all FIFO contents and any hold-off in progress.
- TX FIFO:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
  - tx_valid = (count != 0). tx_data = entry at the read pointer. tx_full = (count == DEPTH).
  - Push: cpu_write=1 and (not full, or a pop occurs in the same cycle). Data is written at the write pointer and becomes visible next cycle. A byte written into an empty FIFO appears on tx_valid/tx_data the following cycle (latency 1).
  - Pop: tx_valid & tx_ready at a rising edge. The read pointer advances.
  - Simultaneous push and pop: count unchanged. This is allowed when full, and such a write is accepted.
  - cpu_write while full with no pop: byte dropped, tx_overflow set to 1. It stays 1 until reset.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid are held stable.
- RX FSM, two states:
  - IDLE: rx_ready=1. On rx_valid=1:
    - capture rx_data into cpu_data_out on that edge;
    - rx_irq=1 for exactly the next cycle;
    - load hold counter with HOLD_CYCLES;
    - go to HOLD.
  - HOLD: rx_ready=0 and rx_data is ignored. The counter decrements each cycle. When the counter reaches 1, go to IDLE next edge.
  - Net effect: rx_ready is low for exactly HOLD_CYCLES cycles after the capture edge.
  - cpu_data_out holds the last captured byte indefinitely. The cpu has no read strobe, so reads never alter state.
  - rx_irq is registered and never asserted for two consecutive cycles.
- TX and RX paths are fully independent. Any combination of events in the same cycle is legal.

Test Plan:
- Reset, then cpu_write with 0x5A while tx_ready=0 -> next cycle tx_valid=1, tx_data=0x5A. tx_data is held stable for 10 cycles; raise tx_ready -> one transfer, then tx_valid=0.
- DEPTH=4, tx_ready=0, write 0x01,0x02,0x03,0x04,0x05 -> tx_full=1 after the 4th write, tx_overflow=1 after the 5th. Drain yields exactly 0x01..0x04 in order.
- FIFO full and tx_ready=1, cpu_write 0x77 in the same cycle as a pop -> count stays 4, tx_overflow stays 0, 0x77 emerges last.
- rx_valid=1 with 0xC3, held continuously -> cpu_data_out=0xC3, rx_irq high exactly 1 cycle, rx_ready low exactly 8 cycles. The next capture occurs on the first cycle rx_ready=1, and rx_irq pulses again.
- Assert async_nreset low mid-HOLD with 2 FIFO entries pending -> all outputs return to reset values immediately. After release, tx_valid=0, rx_ready=1, and no stale bytes emerge.
- More than 2*DEPTH writes with continuous drain (tx_ready=1) -> pointer wrap-around preserves order and no overflow occurs.
